// File: rtl/cplx_mult_param_pkg.sv
// Shared definitions for cplx_mult_param: FSM state encoding, product indices
// and the multiply-step count derived from the number of multipliers.
package cplx_mult_param_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MULT    = 2'd1,
    COMPUTE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [1:0] P_RR = 2'd0;  // a_re * b_re
  localparam logic [1:0] P_II = 2'd1;  // a_im * b_im
  localparam logic [1:0] P_RI = 2'd2;  // a_re * b_im
  localparam logic [1:0] P_IR = 2'd3;  // a_im * b_re

  function automatic int steps_of(input int num_mult);
    return 4 / num_mult;
  endfunction

endpackage

// File: rtl/cplx_mult_param_fsm.sv
// Control FSM for cplx_mult_param: sequences IDLE/MULT/COMPUTE/RESULT, counts
// multiply steps and produces the handshake outputs and datapath enables.
module cplx_mult_param_fsm
  import cplx_mult_param_pkg::*;
#(
  parameter int NUM_MULT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sw_rst,
  input  logic       op_val,
  input  logic       res_ready,
  output logic       op_ready,
  output logic       res_val,
  output logic       busy,
  output logic       load,
  output logic       step_en,
  output logic       compute_en,
  output logic [1:0] step
);

  localparam logic [1:0] LAST_STEP = 2'(steps_of(NUM_MULT) - 1);

  state_t state;

  assign op_ready   = (state == IDLE) | ((state == RESULT) & res_ready);
  assign load       = op_val & op_ready & ~sw_rst;
  assign step_en    = (state == MULT) & ~sw_rst;
  assign compute_en = (state == COMPUTE) & ~sw_rst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      step    <= 2'd0;
      res_val <= 1'b0;
      busy    <= 1'b0;
    end else if (sw_rst) begin
      state   <= IDLE;
      step    <= 2'd0;
      res_val <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_val) begin
            state <= MULT;
            step  <= 2'd0;
            busy  <= 1'b1;
          end
        end
        MULT: begin
          if (step == LAST_STEP) begin
            state <= COMPUTE;
            step  <= 2'd0;
          end else begin
            step <= step + 2'd1;
          end
        end
        COMPUTE: begin
          state   <= RESULT;
          res_val <= 1'b1;
        end
        RESULT: begin
          // Handoff; a waiting operand pair is taken on the same edge
          if (res_ready) begin
            res_val <= 1'b0;
            step    <= 2'd0;
            if (op_val) begin
              state <= MULT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cplx_mult_param.sv
// Sequential complex multiplier with NUM_MULT time-shared multipliers.
// Define CPLX_MULT_CONJ_EN to add the conj_b input (result A*conj(B)).
module cplx_mult_param
  import cplx_mult_param_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_MULT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sw_rst,
  input  logic                op_val,
  output logic                op_ready,
  input  logic [DATA_W-1:0]   a_re,
  input  logic [DATA_W-1:0]   a_im,
  input  logic [DATA_W-1:0]   b_re,
  input  logic [DATA_W-1:0]   b_im,
`ifdef CPLX_MULT_CONJ_EN
  input  logic                conj_b,
`endif
  output logic                res_val,
  input  logic                res_ready,
  output logic [2*DATA_W:0]   res_re,
  output logic [2*DATA_W:0]   res_im,
  output logic                busy,
  output logic [CNT_W-1:0]    done_cnt
);

  localparam int PW = 2 * DATA_W;
  localparam int RW = PW + 1;

  if (NUM_MULT != 1 && NUM_MULT != 2 && NUM_MULT != 4) begin : g_bad_num_mult
    $error("cplx_mult_param: NUM_MULT must be 1, 2 or 4");
  end

  function automatic logic signed [PW-1:0] mul_full(input logic signed [DATA_W-1:0] x,
                                                    input logic signed [DATA_W-1:0] y);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = {{DATA_W{x[DATA_W-1]}}, x};
    ye = {{DATA_W{y[DATA_W-1]}}, y};
    return xe * ye;
  endfunction

  function automatic logic signed [RW-1:0] ext(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  logic       load, step_en, compute_en;
  logic [1:0] step;

  cplx_mult_param_fsm #(.NUM_MULT(NUM_MULT)) u_fsm (
    .clk        (clk),
    .rstn       (rstn),
    .sw_rst     (sw_rst),
    .op_val     (op_val),
    .res_ready  (res_ready),
    .op_ready   (op_ready),
    .res_val    (res_val),
    .busy       (busy),
    .load       (load),
    .step_en    (step_en),
    .compute_en (compute_en),
    .step       (step)
  );

  // Stage p0: operand capture
  logic signed [DATA_W-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
  logic                     conj_p0;
  logic                     conj_in;

`ifdef CPLX_MULT_CONJ_EN
  assign conj_in = conj_b;
`else
  assign conj_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_re_p0 <= '0;
      a_im_p0 <= '0;
      b_re_p0 <= '0;
      b_im_p0 <= '0;
      conj_p0 <= 1'b0;
    end else if (load) begin
      a_re_p0 <= a_re;
      a_im_p0 <= a_im;
      b_re_p0 <= b_re;
      b_im_p0 <= b_im;
      conj_p0 <= conj_in;
    end
  end

  // Stage p1: time-shared multipliers, step k fills products k*NUM_MULT upward
  logic signed [PW-1:0] mul_out [NUM_MULT];
  logic [1:0]           mul_idx [NUM_MULT];
  logic signed [PW-1:0] prod_p1 [4];

  for (genvar m = 0; m < NUM_MULT; m++) begin : g_mul
    logic signed [DATA_W-1:0] opa, opb;
    assign mul_idx[m] = 2'(int'(step) * NUM_MULT + m);
    always_comb begin
      opa = a_re_p0;
      opb = b_re_p0;
      case (mul_idx[m])
        P_RR: begin opa = a_re_p0; opb = b_re_p0; end
        P_II: begin opa = a_im_p0; opb = b_im_p0; end
        P_RI: begin opa = a_re_p0; opb = b_im_p0; end
        P_IR: begin opa = a_im_p0; opb = b_re_p0; end
        default: ;
      endcase
    end
    assign mul_out[m] = mul_full(opa, opb);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) prod_p1[i] <= '0;
    end else if (step_en) begin
      for (int m = 0; m < NUM_MULT; m++) prod_p1[mul_idx[m]] <= mul_out[m];
    end
  end

  // Stage p2: add/sub, one guard bit so extreme operands cannot overflow
  logic signed [RW-1:0] res_re_p2, res_im_p2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_re_p2 <= '0;
      res_im_p2 <= '0;
    end else if (compute_en) begin
      if (conj_p0) begin
        res_re_p2 <= ext(prod_p1[P_RR]) + ext(prod_p1[P_II]);
        res_im_p2 <= ext(prod_p1[P_IR]) - ext(prod_p1[P_RI]);
      end else begin
        res_re_p2 <= ext(prod_p1[P_RR]) - ext(prod_p1[P_II]);
        res_im_p2 <= ext(prod_p1[P_RI]) + ext(prod_p1[P_IR]);
      end
    end
  end

  assign res_re = res_re_p2;
  assign res_im = res_im_p2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_cnt <= '0;
    end else if (sw_rst) begin
      done_cnt <= '0;
    end else if (res_val & res_ready) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cplx_mult_param.sv
// Directed self-checking bench for cplx_mult_param with NUM_MULT = 1, 2 and 4.
module tb_cplx_mult_param;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn, sw_rst;
  logic signed [W-1:0] a_re, a_im, b_re, b_im;
`ifdef CPLX_MULT_CONJ_EN
  logic conj_b;
`endif

  logic op_val1, op_val2, op_val4;
  logic res_ready1, res_ready2, res_ready4;
  logic op_ready1, op_ready2, op_ready4;
  logic res_val1, res_val2, res_val4;
  logic busy1, busy2, busy4;
  logic [2*W:0] res_re1, res_im1, res_re2, res_im2, res_re4, res_im4;
  logic [15:0] done_cnt1, done_cnt2, done_cnt4;

  int errs = 0;
  int checks = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  cplx_mult_param #(.DATA_W(W), .NUM_MULT(2), .CNT_W(16)) dut2 (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val2), .op_ready(op_ready2),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
`ifdef CPLX_MULT_CONJ_EN
    .conj_b(conj_b),
`endif
    .res_val(res_val2), .res_ready(res_ready2), .res_re(res_re2), .res_im(res_im2),
    .busy(busy2), .done_cnt(done_cnt2)
  );

  cplx_mult_param #(.DATA_W(W), .NUM_MULT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val1), .op_ready(op_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
`ifdef CPLX_MULT_CONJ_EN
    .conj_b(conj_b),
`endif
    .res_val(res_val1), .res_ready(res_ready1), .res_re(res_re1), .res_im(res_im1),
    .busy(busy1), .done_cnt(done_cnt1)
  );

  cplx_mult_param #(.DATA_W(W), .NUM_MULT(4), .CNT_W(16)) dut4 (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val4), .op_ready(op_ready4),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
`ifdef CPLX_MULT_CONJ_EN
    .conj_b(conj_b),
`endif
    .res_val(res_val4), .res_ready(res_ready4), .res_re(res_re4), .res_im(res_im4),
    .busy(busy4), .done_cnt(done_cnt4)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int ar, input int ai, input int br, input int bi);
    a_re = W'(ar);
    a_im = W'(ai);
    b_re = W'(br);
    b_im = W'(bi);
  endtask

  initial begin
    rstn = 1'b0; sw_rst = 1'b0;
    op_val1 = 0; op_val2 = 0; op_val4 = 0;
    res_ready1 = 1; res_ready2 = 0; res_ready4 = 1;
`ifdef CPLX_MULT_CONJ_EN
    conj_b = 1'b0;
`endif
    set_ops(0, 0, 0, 0);
    tick(); tick();

    chk("rst_op_ready", op_ready2, 1);
    chk("rst_res_val", res_val2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done_cnt", done_cnt2, 0);
    chk("rst_res_re", $signed(res_re2), 0);
    rstn = 1'b1;
    tick();

    // (3+j4)*(5-j2) = 23+j14, NUM_MULT=2
    set_ops(3, 4, 5, -2);
    op_val2 = 1;
    tick();
    op_val2 = 0;
    chk("accept_busy", busy2, 1);
    chk("accept_op_ready", op_ready2, 0);
    n = 0;
    while (!res_val2 && n < 20) begin tick(); n++; end
    chk("lat_m2", n, 3);
    chk("m2_re", $signed(res_re2), 23);
    chk("m2_im", $signed(res_im2), 14);

    // Hold in RESULT with res_ready low
    for (int i = 0; i < 10; i++) tick();
    chk("hold_res_val", res_val2, 1);
    chk("hold_op_ready", op_ready2, 0);
    chk("hold_re", $signed(res_re2), 23);
    chk("hold_im", $signed(res_im2), 14);

    // Back-to-back accept of the corner case (-128-j128)^2 = 0+j32768
    set_ops(-128, -128, -128, -128);
    op_val2 = 1;
    res_ready2 = 1;
    #1;
    chk("b2b_op_ready", op_ready2, 1);
    tick();
    op_val2 = 0;
    chk("b2b_done_cnt", done_cnt2, 1);
    chk("b2b_res_val", res_val2, 0);
    chk("b2b_busy", busy2, 1);
    n = 0;
    while (!res_val2 && n < 20) begin tick(); n++; end
    chk("lat_corner", n, 3);
    chk("corner_re", $signed(res_re2), 0);
    chk("corner_im", $signed(res_im2), 32768);
    tick();
    chk("handoff_done_cnt", done_cnt2, 2);
    chk("handoff_idle_busy", busy2, 0);
    chk("handoff_op_ready", op_ready2, 1);

    // (-7+j2)*(3+j5) = -31-j29
    set_ops(-7, 2, 3, 5);
    op_val2 = 1;
    tick();
    op_val2 = 0;
    n = 0;
    while (!res_val2 && n < 20) begin tick(); n++; end
    chk("neg_re", $signed(res_re2), -31);
    chk("neg_im", $signed(res_im2), -29);
    tick();
    chk("neg_done_cnt", done_cnt2, 3);

    // sw_rst during MULT step 0
    set_ops(1, 1, 1, 1);
    op_val2 = 1;
    tick();
    op_val2 = 0;
    sw_rst = 1;
    tick();
    sw_rst = 0;
    chk("swrst_busy", busy2, 0);
    chk("swrst_op_ready", op_ready2, 1);
    chk("swrst_done_cnt", done_cnt2, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (res_val2) seen = 1'b1;
      tick();
    end
    chk("swrst_no_res_val", seen, 0);
    chk("swrst_res_held", $signed(res_re2), -31);

    // Asynchronous rstn in the middle of RESULT
    res_ready2 = 0;
    set_ops(3, 4, 5, -2);
    op_val2 = 1;
    tick();
    op_val2 = 0;
    n = 0;
    while (!res_val2 && n < 20) begin tick(); n++; end
    chk("pre_rst_res_val", res_val2, 1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_res_val", res_val2, 0);
    chk("arst_res_re", $signed(res_re2), 0);
    chk("arst_res_im", $signed(res_im2), 0);
    chk("arst_busy", busy2, 0);
    chk("arst_op_ready", op_ready2, 1);
    #1 rstn = 1'b1;
    tick();

    // Same operands on NUM_MULT=1 and NUM_MULT=4
    set_ops(3, 4, 5, -2);
    op_val1 = 1;
    tick();
    op_val1 = 0;
    n = 0;
    while (!res_val1 && n < 20) begin tick(); n++; end
    chk("lat_m1", n, 5);
    chk("m1_re", $signed(res_re1), 23);
    chk("m1_im", $signed(res_im1), 14);
    tick();
    chk("m1_done_cnt", done_cnt1, 1);

    op_val4 = 1;
    tick();
    op_val4 = 0;
    n = 0;
    while (!res_val4 && n < 20) begin tick(); n++; end
    chk("lat_m4", n, 2);
    chk("m4_re", $signed(res_re4), 23);
    chk("m4_im", $signed(res_im4), 14);
    tick();
    chk("m4_done_cnt", done_cnt4, 1);

`ifdef CPLX_MULT_CONJ_EN
    // (3+j4)*conj(5-j2) = 7+j26
    res_ready2 = 1;
    set_ops(3, 4, 5, -2);
    conj_b = 1;
    op_val2 = 1;
    tick();
    op_val2 = 0;
    conj_b = 0;
    n = 0;
    while (!res_val2 && n < 20) begin tick(); n++; end
    chk("conj_re", $signed(res_re2), 7);
    chk("conj_im", $signed(res_im2), 26);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
